// File: rtl/bec_ladder_seq.sv
// Sequential Montgomery-ladder controller for binary Edwards curves: loads the
// working set, drives an external ACB unit through seven steps per key bit, then unloads.
module bec_ladder_seq #(
  parameter int M        = 163,
  parameter int KEY_BITS = 163,
  parameter int CW       = $clog2(KEY_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_data,
  input  logic          load_we,
  input  logic [2:0]    load_sel,
  input  logic [M-1:0]  data_in,
  input  logic          start,
  input  logic          abort,
  input  logic          out_sel,
  input  logic          unload_ack,
  output logic          acb_start,
  output logic [M-1:0]  acb_a,
  output logic [M-1:0]  acb_b,
  output logic          acb_cfg,
  input  logic          acb_done,
  input  logic [M-1:0]  acb_c,
  output logic [3:0]    status,
  output logic [M-1:0]  data_out,
  output logic          done,
  output logic          next_key,
  output logic [CW-1:0] iter,
  output logic          aborted
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_UNLOAD = 3'd5;

  localparam logic [2:0]    LAST_STEP = 3'd6;
  localparam logic [CW-1:0] LAST_ITER = CW'(KEY_BITS - 1);

  logic [2:0]          state;
  logic [2:0]          step;
  logic [M-1:0]        reg_a, reg_b, reg_c, reg_d, reg_dd, reg_winv;
  logic [KEY_BITS-1:0] key_sh;
  logic                kb, running, op_valid;
  logic [M-1:0]        p, q, r, s, np, nq, nr, ns, op_a, op_b;
  logic                op_cfg;

  // The key is consumed MSB first by shifting, so the current bit is always the top one.
  assign kb       = key_sh[KEY_BITS-1];
  assign running  = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_NEXT);
  assign op_valid = (state == ST_ISSUE) || (state == ST_WAIT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    p      = kb ? reg_a : reg_c;
    q      = kb ? reg_b : reg_d;
    r      = kb ? reg_c : reg_a;
    s      = kb ? reg_d : reg_b;
    op_a   = '0;
    op_b   = '0;
    op_cfg = 1'b0;
    np     = p;
    nq     = q;
    nr     = r;
    ns     = s;
    case (step)
      3'd0: begin op_a = p;        op_b = s;     np = acb_c;                        end
      3'd1: begin op_a = q;        op_b = r;     np = p ^ acb_c;                    end
      3'd2: begin op_a = q;        op_b = s;     nq = acb_c;                        end
      3'd3: begin op_a = reg_winv; op_b = p;     op_cfg = 1'b1;
                  np = p ^ acb_c;  nq = q ^ acb_c;                                  end
      3'd4: begin op_a = r;        op_b = r ^ s; nr = acb_c;                        end
      3'd5: begin op_a = s;        op_b = s;     ns = acb_c;                        end
      3'd6: begin op_a = reg_dd;   op_b = s;     op_cfg = 1'b1; ns = r ^ acb_c;     end
      default: ;
    endcase
  end

  assign acb_start = (state == ST_ISSUE);
  assign acb_a     = op_valid ? op_a : '0;
  assign acb_b     = op_valid ? op_b : '0;
  assign acb_cfg   = op_valid & op_cfg;
  assign next_key  = (state == ST_NEXT);
  assign done      = (state == ST_UNLOAD);
  assign data_out  = (state == ST_UNLOAD) ? (out_sel ? reg_b : reg_a) : '0;

  always_comb begin
    case (state)
      ST_IDLE:                     status = 4'b1000;
      ST_LOAD:                     status = 4'b0100;
      ST_ISSUE, ST_WAIT, ST_NEXT:  status = 4'b0010;
      ST_UNLOAD:                   status = 4'b0001;
      default:                     status = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      step     <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      reg_c    <= '0;
      reg_d    <= '0;
      reg_dd   <= '0;
      reg_winv <= '0;
      key_sh   <= '0;
      iter     <= '0;
      aborted  <= 1'b0;
    end else if (running && abort) begin
      // Abort wins over a same-cycle acb_done; that writeback is dropped.
      state    <= ST_IDLE;
      step     <= '0;
      aborted  <= 1'b1;
      reg_a    <= '0;
      reg_b    <= '0;
      reg_c    <= '0;
      reg_d    <= '0;
      reg_dd   <= '0;
      reg_winv <= '0;
      key_sh   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (load_data) begin
            state   <= ST_LOAD;
            aborted <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_we) begin
            case (load_sel)
              3'd0: reg_a    <= data_in;
              3'd1: reg_b    <= data_in;
              3'd2: reg_c    <= data_in;
              3'd3: reg_d    <= data_in;
              3'd4: reg_dd   <= data_in;
              3'd5: reg_winv <= data_in;
              3'd6: key_sh   <= data_in[KEY_BITS-1:0];
              default: ;
            endcase
          end
          if (start) begin
            state <= ST_ISSUE;
            step  <= '0;
            iter  <= '0;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (acb_done) begin
            reg_a <= kb ? np : nr;
            reg_b <= kb ? nq : ns;
            reg_c <= kb ? nr : np;
            reg_d <= kb ? ns : nq;
            if (step == LAST_STEP) begin
              state <= ST_NEXT;
            end else begin
              step  <= step + 3'd1;
              state <= ST_ISSUE;
            end
          end
        end
        ST_NEXT: begin
          iter   <= iter + CW'(1);
          key_sh <= key_sh << 1;
          step   <= '0;
          state  <= (iter == LAST_ITER) ? ST_UNLOAD : ST_ISSUE;
        end
        ST_UNLOAD: begin
          if (unload_ack) begin
            state    <= ST_IDLE;
            reg_c    <= '0;
            reg_d    <= '0;
            reg_dd   <= '0;
            reg_winv <= '0;
            key_sh   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bec_ladder_seq.sv
// Self-checking bench for bec_ladder_seq: a small (M=8) and a default-size instance share one
// ACB model; every expected ACB request is queued by a golden ladder model and checked on issue.
module tb_bec_ladder_seq;

  localparam int SM = 8;
  localparam int SK = 4;
  localparam int BK = 163;
  localparam int W  = 163;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cfg;
  } op_t;

  logic         clk = 1'b0;
  logic         rst, load_data, load_we, start, abort, out_sel, unload_ack, acb_done, sel_big;
  logic [2:0]   load_sel;
  logic [W-1:0] data_in, acb_c;

  logic          s_acb_start, s_acb_cfg, s_done, s_next_key, s_aborted;
  logic [SM-1:0] s_acb_a, s_acb_b, s_data_out;
  logic [3:0]    s_status;
  logic [2:0]    s_iter;
  logic          b_acb_start, b_acb_cfg, b_done, b_next_key, b_aborted;
  logic [W-1:0]  b_acb_a, b_acb_b, b_data_out;
  logic [3:0]    b_status;
  logic [7:0]    b_iter;

  logic         cur_start, cur_cfg, cur_done, cur_next_key, cur_aborted;
  logic [W-1:0] cur_a, cur_b, cur_dout;
  logic [3:0]   cur_status;
  int           cur_iter;

  int   checks = 0, failures = 0;
  int   acb_lat = 3, acb_cnt = 0, n_starts = 0, n_dones = 0, cur_mw = SM;
  bit   acb_pending = 1'b0, stub_rot = 1'b1;
  logic [W-1:0] acb_res;
  op_t  sb_q[$];
  logic [W-1:0] vals [7];

  always #5 clk = ~clk;

  bec_ladder_seq #(.M(SM), .KEY_BITS(SK)) u_small (
    .clk(clk), .rst(rst), .load_data(load_data & ~sel_big), .load_we(load_we),
    .load_sel(load_sel), .data_in(data_in[SM-1:0]), .start(start), .abort(abort),
    .out_sel(out_sel), .unload_ack(unload_ack), .acb_start(s_acb_start), .acb_a(s_acb_a),
    .acb_b(s_acb_b), .acb_cfg(s_acb_cfg), .acb_done(acb_done & ~sel_big), .acb_c(acb_c[SM-1:0]),
    .status(s_status), .data_out(s_data_out), .done(s_done), .next_key(s_next_key),
    .iter(s_iter), .aborted(s_aborted)
  );

  bec_ladder_seq u_big (
    .clk(clk), .rst(rst), .load_data(load_data & sel_big), .load_we(load_we),
    .load_sel(load_sel), .data_in(data_in), .start(start), .abort(abort),
    .out_sel(out_sel), .unload_ack(unload_ack), .acb_start(b_acb_start), .acb_a(b_acb_a),
    .acb_b(b_acb_b), .acb_cfg(b_acb_cfg), .acb_done(acb_done & sel_big), .acb_c(acb_c),
    .status(b_status), .data_out(b_data_out), .done(b_done), .next_key(b_next_key),
    .iter(b_iter), .aborted(b_aborted)
  );

  always_comb begin
    if (sel_big) begin
      cur_start = b_acb_start; cur_cfg = b_acb_cfg; cur_a = b_acb_a; cur_b = b_acb_b;
      cur_done = b_done; cur_next_key = b_next_key; cur_aborted = b_aborted;
      cur_dout = b_data_out; cur_status = b_status; cur_iter = int'(b_iter);
    end else begin
      cur_start = s_acb_start; cur_cfg = s_acb_cfg;
      cur_a = {{(W-SM){1'b0}}, s_acb_a}; cur_b = {{(W-SM){1'b0}}, s_acb_b};
      cur_done = s_done; cur_next_key = s_next_key; cur_aborted = s_aborted;
      cur_dout = {{(W-SM){1'b0}}, s_data_out}; cur_status = s_status; cur_iter = int'(s_iter);
    end
  end

  function automatic logic [W-1:0] mask_of(input int mw);
    return {W{1'b1}} >> (W - mw);
  endfunction

  // The small instance uses a rotate-XOR stub so that squaring steps do not collapse to zero.
  function automatic logic [W-1:0] stub(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input int mw, input bit rot);
    logic [W-1:0] m;
    m = mask_of(mw);
    if (rot) return (a ^ ((b << 1) | (b >> (mw - 1)))) & m;
    return (a ^ b) & m;
  endfunction

  // ACB model: fixed latency acb_lat from the issue cycle; each request is checked against the queue.
  always @(negedge clk) begin
    op_t e;
    acb_done = 1'b0;
    if (acb_pending) begin
      acb_cnt--;
      if (acb_cnt == 0) begin
        acb_done = 1'b1; acb_c = acb_res; acb_pending = 1'b0; n_dones++;
      end
    end
    if (cur_start) begin
      n_starts++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL acb_unexpected: request a=%h b=%h with nothing expected", cur_a, cur_b);
      end else begin
        e = sb_q.pop_front();
        if ({cur_a, cur_b, cur_cfg} !== {e.a, e.b, e.cfg}) begin
          failures++;
          $display("FAIL acb_ops: got a=%h b=%h cfg=%0b, expected a=%h b=%h cfg=%0b",
                   cur_a, cur_b, cur_cfg, e.a, e.b, e.cfg);
        end
      end
      acb_res = stub(cur_a, cur_b, cur_mw, stub_rot);
      acb_pending = 1'b1;
      acb_cnt = acb_lat;
    end
  end

  task automatic gstep(input logic [W-1:0] a, input logic [W-1:0] b, input logic cfg,
                       input int mw, input bit rot, output logic [W-1:0] t);
    op_t e;
    e.a = a; e.b = b; e.cfg = cfg;
    sb_q.push_back(e);
    t = stub(a, b, mw, rot);
  endtask

  task automatic gold(input int mw, input int kbits, input bit rot,
                      output logic [W-1:0] fa, output logic [W-1:0] fb);
    logic [W-1:0] m, ra, rb, rc, rd, rdd, rw, key, p, q, r, s, t;
    bit k;
    m = mask_of(mw);
    ra = vals[0] & m; rb = vals[1] & m; rc = vals[2] & m; rd = vals[3] & m;
    rdd = vals[4] & m; rw = vals[5] & m; key = vals[6] & mask_of(kbits);
    for (int i = kbits - 1; i >= 0; i--) begin
      k = key[i];
      if (k) begin p = ra; q = rb; r = rc; s = rd; end
      else   begin p = rc; q = rd; r = ra; s = rb; end
      gstep(p, s, 1'b0, mw, rot, t);     p = t;
      gstep(q, r, 1'b0, mw, rot, t);     p = p ^ t;
      gstep(q, s, 1'b0, mw, rot, t);     q = t;
      gstep(rw, p, 1'b1, mw, rot, t);    p = p ^ t; q = q ^ t;
      gstep(r, r ^ s, 1'b0, mw, rot, t); r = t;
      gstep(s, s, 1'b0, mw, rot, t);     s = t;
      gstep(rdd, s, 1'b1, mw, rot, t);   s = r ^ t;
      if (k) begin ra = p; rb = q; rc = r; rd = s; end
      else   begin rc = p; rd = q; ra = r; rb = s; end
    end
    fa = ra;
    fb = rb;
  endtask

  function automatic logic [W-1:0] rand_w();
    return W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic load_regs(input bit skip_writes);
    @(negedge clk); load_data = 1'b1;
    @(negedge clk); load_data = 1'b0;
    if (!skip_writes) begin
      for (int i = 0; i < 7; i++) begin
        load_we = 1'b1; load_sel = 3'(i); data_in = vals[i];
        @(negedge clk);
      end
    end
    load_we = 1'b0;
  endtask

  // Pulses start from a negedge in LOAD; cyc counts edges from the start edge to UNLOAD entry.
  task automatic run_to_unload(input bit interfere, output int cyc, output int pulses,
                               output op_t first, output logic first_start);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    first.a = cur_a; first.b = cur_b; first.cfg = cur_cfg; first_start = cur_start;
    cyc = 0; pulses = 0;
    while (cur_status != 4'b0001 && cyc < 6000) begin
      if (cur_next_key) pulses++;
      if (interfere && cyc >= 5 && cyc < 9) begin
        load_we = 1'b1; load_sel = 3'(cyc - 5); data_in = {W{1'b1}}; start = 1'b1;
      end else begin
        load_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    load_we = 1'b0; start = 1'b0;
  endtask

  task automatic do_unload();
    @(negedge clk); unload_ack = 1'b1;
    @(negedge clk); unload_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_status !== 4'b1000) begin failures++; $display("FAIL reset_status: got %b expected 1000", s_status); end
    checks++;
    if ({s_acb_start, s_acb_cfg, s_acb_a, s_acb_b} !== '0) begin
      failures++; $display("FAIL reset_acb: got start=%b a=%h b=%h cfg=%b expected all 0", s_acb_start, s_acb_a, s_acb_b, s_acb_cfg);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_data_out, s_done, s_next_key, s_iter, s_aborted} !== '0) begin
      failures++; $display("FAIL reset_outs: got dout=%h done=%b nk=%b iter=%0d ab=%b expected all 0", s_data_out, s_done, s_next_key, s_iter, s_aborted);
    end
    checks++;
    if (b_status !== 4'b1000) begin failures++; $display("FAIL reset_big_status: got %b expected 1000", b_status); end
  endtask

  task automatic test_latency();
    logic [W-1:0] fa, fb; int cyc, pl; op_t f; logic fs;
    for (int n = 0; n < 3; n++) begin
      for (int j = 0; j < 6; j++) vals[j] = W'($urandom());
      vals[6] = (n == 0) ? W'(4'hA) : W'($urandom());
      load_regs(1'b0);
      gold(SM, SK, 1'b1, fa, fb);
      run_to_unload(1'b0, cyc, pl, f, fs);
      checks++;
      if (cyc !== SK * (7 * (1 + 3) + 1)) begin failures++; $display("FAIL latency: got %0d expected %0d", cyc, SK * (7 * (1 + 3) + 1)); end
      checks++;
      if (pl !== SK) begin failures++; $display("FAIL next_key_pulses: got %0d expected %0d", pl, SK); end
      checks++;
      if (cur_iter !== SK || cur_done !== 1'b1) begin failures++; $display("FAIL unload_iter_done: got iter=%0d done=%b expected %0d 1", cur_iter, cur_done, SK); end
      checks++;
      if (sb_q.size() !== 0) begin failures++; $display("FAIL sb_leftover: got %0d expected 0", sb_q.size()); end
      out_sel = 1'b0; #1;
      checks++;
      if (cur_dout !== fa) begin failures++; $display("FAIL result_a: got %h expected %h", cur_dout, fa); end
      out_sel = 1'b1; #1;
      checks++;
      if (cur_dout !== fb) begin failures++; $display("FAIL result_b: got %h expected %h", cur_dout, fb); end
      out_sel = 1'b0;
      do_unload();
      checks++;
      if (cur_status !== 4'b1000 || cur_dout !== '0) begin failures++; $display("FAIL after_unload: got status=%b dout=%h expected 1000 0", cur_status, cur_dout); end
    end
  endtask

  task automatic test_first_issue();
    logic [W-1:0] fa, fb, ea, eb; int cyc, pl; op_t f; logic fs; logic [3:0] key;
    for (int n = 0; n < 2; n++) begin
      key = (n == 0) ? 4'h5 : 4'hA;
      vals[0] = W'(8'h11); vals[1] = W'(8'h22); vals[2] = W'(8'h33); vals[3] = W'(8'h44);
      vals[4] = W'($urandom()); vals[5] = W'($urandom()); vals[6] = W'(key);
      ea = key[3] ? W'(8'h11) : W'(8'h33);
      eb = key[3] ? W'(8'h44) : W'(8'h22);
      load_regs(1'b0);
      gold(SM, SK, 1'b1, fa, fb);
      run_to_unload(1'b0, cyc, pl, f, fs);
      checks++;
      if (fs !== 1'b1 || f.a !== ea || f.b !== eb || f.cfg !== 1'b0) begin
        failures++; $display("FAIL first_issue: got start=%b a=%h b=%h cfg=%b expected 1 %h %h 0", fs, f.a, f.b, f.cfg, ea, eb);
      end
      out_sel = 1'b0; #1;
      checks++;
      if (cur_dout !== fa) begin failures++; $display("FAIL fi_result_a: got %h expected %h", cur_dout, fa); end
      out_sel = 1'b1; #1;
      checks++;
      if (cur_dout !== fb) begin failures++; $display("FAIL fi_result_b: got %h expected %h", cur_dout, fb); end
      out_sel = 1'b0;
      do_unload();
    end
  endtask

  task automatic test_ignore();
    logic [W-1:0] fa, fb; int cyc, pl; op_t f; logic fs;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (cur_status !== 4'b1000) begin failures++; $display("FAIL start_in_idle: got %b expected 1000", cur_status); end
    for (int j = 0; j < 7; j++) vals[j] = W'($urandom());
    load_regs(1'b0);
    gold(SM, SK, 1'b1, fa, fb);
    run_to_unload(1'b1, cyc, pl, f, fs);
    checks++;
    if (cyc !== 116) begin failures++; $display("FAIL ign_latency: got %0d expected 116", cyc); end
    @(negedge clk); load_we = 1'b1; load_sel = 3'd0; data_in = {W{1'b1}}; start = 1'b1; abort = 1'b1;
    @(negedge clk); load_sel = 3'd1;
    @(negedge clk); load_we = 1'b0; start = 1'b0; abort = 1'b0;
    checks++;
    if (cur_status !== 4'b0001) begin failures++; $display("FAIL unload_hold: got %b expected 0001", cur_status); end
    out_sel = 1'b0; #1;
    checks++;
    if (cur_dout !== fa) begin failures++; $display("FAIL ign_result_a: got %h expected %h", cur_dout, fa); end
    out_sel = 1'b1; #1;
    checks++;
    if (cur_dout !== fb) begin failures++; $display("FAIL ign_result_b: got %h expected %h", cur_dout, fb); end
    out_sel = 1'b0;
    do_unload();
  endtask

  task automatic test_abort();
    logic [W-1:0] fa, fb; int cyc, pl, base_d, base_s; op_t f; logic fs; bit hit;
    for (int j = 0; j < 6; j++) vals[j] = W'($urandom()) | W'(1);
    vals[6] = W'(4'hB);
    load_regs(1'b0);
    gold(SM, SK, 1'b1, fa, fb);
    base_d = n_dones;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      #1;
      if (acb_done && (n_dones - base_d) == 11) begin abort = 1'b1; hit = 1'b1; end
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL abort_window: got no s3 done on bit 2 expected one"); end
    @(negedge clk); abort = 1'b0; #1;
    checks++;
    if (cur_status !== 4'b1000 || cur_aborted !== 1'b1 || cur_start !== 1'b0) begin
      failures++; $display("FAIL abort_state: got status=%b aborted=%b start=%b expected 1000 1 0", cur_status, cur_aborted, cur_start);
    end
    sb_q.delete();
    base_s = n_starts;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (n_starts !== base_s) begin failures++; $display("FAIL abort_quiet: got %0d requests expected 0", n_starts - base_s); end
    load_regs(1'b1);
    checks++;
    if (cur_aborted !== 1'b0 || cur_status !== 4'b0100) begin failures++; $display("FAIL reload_clear: got aborted=%b status=%b expected 0 0100", cur_aborted, cur_status); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (cur_status !== 4'b0100) begin failures++; $display("FAIL abort_in_load: got %b expected 0100", cur_status); end
    for (int j = 0; j < 7; j++) vals[j] = '0;
    gold(SM, SK, 1'b1, fa, fb);
    run_to_unload(1'b0, cyc, pl, f, fs);
    out_sel = 1'b0; #1;
    checks++;
    if (cur_dout !== '0 || cyc !== 116) begin failures++; $display("FAIL zeroed_a: got dout=%h cyc=%0d expected 0 116", cur_dout, cyc); end
    out_sel = 1'b1; #1;
    checks++;
    if (cur_dout !== '0) begin failures++; $display("FAIL zeroed_b: got %h expected 0", cur_dout); end
    out_sel = 1'b0;
    do_unload();
  endtask

  task automatic test_rst_mid();
    logic [W-1:0] fa, fb; int cyc, pl, base_s, base_d; op_t f; logic fs; bit hit;
    for (int j = 0; j < 7; j++) vals[j] = W'($urandom());
    load_regs(1'b0);
    gold(SM, SK, 1'b1, fa, fb);
    base_s = n_starts;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      #1;
      if ((n_starts - base_s) == 5) hit = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rst_window: got no s4 issue expected one"); end
    base_d = n_dones;
    @(negedge clk); #1 rst = 1'b1; #1;
    checks++;
    if (cur_status !== 4'b1000 || cur_start !== 1'b0) begin failures++; $display("FAIL rst_mid: got status=%b start=%b expected 1000 0", cur_status, cur_start); end
    @(negedge clk); rst = 1'b0;
    sb_q.delete();
    for (int c = 0; c < 10 && n_dones == base_d; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cur_status !== 4'b1000 || cur_iter !== 0 || cur_start !== 1'b0) begin
      failures++; $display("FAIL late_done: got status=%b iter=%0d start=%b expected 1000 0 0", cur_status, cur_iter, cur_start);
    end
    for (int j = 0; j < 7; j++) vals[j] = W'($urandom());
    load_regs(1'b0);
    gold(SM, SK, 1'b1, fa, fb);
    run_to_unload(1'b0, cyc, pl, f, fs);
    out_sel = 1'b0; #1;
    checks++;
    if (cur_dout !== fa || cyc !== 116) begin failures++; $display("FAIL rerun_a: got %h cyc=%0d expected %h 116", cur_dout, cyc, fa); end
    out_sel = 1'b1; #1;
    checks++;
    if (cur_dout !== fb) begin failures++; $display("FAIL rerun_b: got %h expected %h", cur_dout, fb); end
    out_sel = 1'b0;
    do_unload();
  endtask

  task automatic test_big();
    logic [W-1:0] fa, fb; int cyc, pl; op_t f; logic fs;
    sel_big = 1'b1; cur_mw = W; stub_rot = 1'b0; acb_lat = 1;
    for (int j = 0; j < 7; j++) vals[j] = rand_w();
    load_regs(1'b0);
    gold(W, BK, 1'b0, fa, fb);
    run_to_unload(1'b0, cyc, pl, f, fs);
    checks++;
    if (cyc !== BK * (7 * (1 + 1) + 1)) begin failures++; $display("FAIL big_latency: got %0d expected %0d", cyc, BK * 15); end
    checks++;
    if (pl !== BK || cur_iter !== BK) begin failures++; $display("FAIL big_iter: got pulses=%0d iter=%0d expected %0d", pl, cur_iter, BK); end
    out_sel = 1'b0; #1;
    checks++;
    if (cur_dout !== fa) begin failures++; $display("FAIL big_result_a: got %h expected %h", cur_dout, fa); end
    out_sel = 1'b1; #1;
    checks++;
    if (cur_dout !== fb) begin failures++; $display("FAIL big_result_b: got %h expected %h", cur_dout, fb); end
    out_sel = 1'b0; #1;
    checks++;
    if (cur_dout !== fa) begin failures++; $display("FAIL big_toggle_back: got %h expected %h", cur_dout, fa); end
    do_unload();
    sel_big = 1'b0; cur_mw = SM; stub_rot = 1'b1; acb_lat = 3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_data = 1'b0; load_we = 1'b0; load_sel = 3'd0; data_in = '0;
    start = 1'b0; abort = 1'b0; out_sel = 1'b0; unload_ack = 1'b0;
    acb_done = 1'b0; acb_c = '0; sel_big = 1'b0;
    test_reset();
    test_latency();
    test_first_issue();
    test_ignore();
    test_abort();
    test_rst_mid();
    test_big();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
